// File: rtl/cavlc_blk_sched_if.sv
// Residual block scheduler bus.
// master: the macroblock-level controller that issues start and the latched
//         MB parameters, and watches busy/mb_done.
// slave : cavlc_blk_sched, which drives the scan handshake toward the CAVLC
//         control FSM along with the current block category/index.
interface cavlc_blk_sched_if;
  logic       start;
  logic [2:0] mb_type;
  logic [3:0] cbp_luma;
  logic [1:0] cbp_chroma;
  logic       scan_en;
  logic       scan_done;
  logic [2:0] blk_cat;
  logic [3:0] blk_idx;
  logic       busy;
  logic       mb_done;

  modport master (
    output start, mb_type, cbp_luma, cbp_chroma,
    input  scan_en, scan_done, blk_cat, blk_idx, busy, mb_done
  );

  modport slave (
    input  start, mb_type, cbp_luma, cbp_chroma,
    output scan_en, scan_done, blk_cat, blk_idx, busy, mb_done
  );
endinterface

// File: rtl/cavlc_blk_sched.sv
// Residual block scheduler for the CAVLC encoder.
// Walks the coded residual blocks of one macroblock in bitstream order
// (luma DC, luma AC/4x4, chroma DC, chroma AC), skipping CBP-masked blocks,
// and gives each coded block one BLK_CYCLES-long scan slot.
// Ports:
//   clk   - clock
//   rst_n - synchronous active-low reset
//   bus   - slave side of cavlc_blk_sched_if (start/MB parameters in;
//           scan_en, scan_done, blk_cat, blk_idx, busy, mb_done out).
// All outputs are registered.
module cavlc_blk_sched #(
  parameter int BLK_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  cavlc_blk_sched_if.slave    bus
);

  localparam int CW = (BLK_CYCLES > 1) ? $clog2(BLK_CYCLES) : 1;

  localparam logic [2:0] CAT_I16DC = 3'd0;
  localparam logic [2:0] CAT_I16AC = 3'd1;
  localparam logic [2:0] CAT_LUMA4 = 3'd2;
  localparam logic [2:0] CAT_CDC   = 3'd3;
  localparam logic [2:0] CAT_CAC   = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t       state_q;
  logic [CW-1:0] cyc_q;
  logic         i16_q;
  logic [3:0]   cbp_l_q;
  logic [1:0]   cbp_c_q;
  logic         scan_en_q;
  logic         scan_done_q;
  logic [2:0]   cat_q;
  logic [3:0]   idx_q;
  logic         busy_q;
  logic         mb_done_q;

  // Returns {found, cat, idx} of the next coded block after (cat, idx), or of
  // the first coded block when first=1. Luma is searched a whole 8x8 group at
  // a time, so the next block is always known within one cycle.
  function automatic logic [7:0] seek(
    input logic       first,
    input logic [2:0] cat,
    input logic [3:0] idx,
    input logic       i16,
    input logic [3:0] cl,
    input logic [1:0] cc
  );
    logic        found;
    logic [2:0]  ncat;
    logic [3:0]  nidx;
    logic        luma_srch;
    int unsigned g0;
    found     = 1'b0;
    ncat      = '0;
    nidx      = '0;
    luma_srch = 1'b0;
    g0        = 0;
    if (first) begin
      if (i16) begin
        found = 1'b1;
        ncat  = CAT_I16DC;
      end else begin
        luma_srch = 1'b1;
      end
    end else begin
      case (cat)
        CAT_I16DC: luma_srch = 1'b1;
        CAT_I16AC, CAT_LUMA4: begin
          if (idx[1:0] != 2'd3) begin
            found = 1'b1;
            ncat  = cat;
            nidx  = idx + 4'd1;
          end else begin
            luma_srch = 1'b1;
            g0        = 32'(idx[3:2]) + 1;
          end
        end
        CAT_CDC: begin
          if (idx == 4'd0) begin
            found = 1'b1;
            ncat  = CAT_CDC;
            nidx  = 4'd1;
          end else if (cc[1]) begin
            found = 1'b1;
            ncat  = CAT_CAC;
          end
        end
        CAT_CAC: begin
          if (idx != 4'd7) begin
            found = 1'b1;
            ncat  = CAT_CAC;
            nidx  = idx + 4'd1;
          end
        end
        default: found = 1'b0;
      endcase
    end
    if (luma_srch) begin
      for (int unsigned g = 0; g < 4; g++) begin
        if (!found && g >= g0 && cl[g]) begin
          found = 1'b1;
          ncat  = i16 ? CAT_I16AC : CAT_LUMA4;
          nidx  = 4'(g * 4);
        end
      end
      if (!found && cc != 2'd0) begin
        found = 1'b1;
        ncat  = CAT_CDC;
        nidx  = '0;
      end
    end
    return {found, ncat, nidx};
  endfunction

  logic [7:0] first_w;
  logic [7:0] next_w;

  always_comb begin
    first_w = seek(1'b1, '0, '0, bus.mb_type == 3'd2, bus.cbp_luma, bus.cbp_chroma);
    next_w  = seek(1'b0, cat_q, idx_q, i16_q, cbp_l_q, cbp_c_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cyc_q       <= '0;
      i16_q       <= 1'b0;
      cbp_l_q     <= '0;
      cbp_c_q     <= '0;
      scan_en_q   <= 1'b0;
      scan_done_q <= 1'b0;
      cat_q       <= '0;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      mb_done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && bus.mb_type != 3'd0) begin
            i16_q   <= (bus.mb_type == 3'd2);
            cbp_l_q <= bus.cbp_luma;
            cbp_c_q <= bus.cbp_chroma;
            busy_q  <= 1'b1;
            if (first_w[7]) begin
              state_q   <= S_LEAD;
              scan_en_q <= 1'b1;
              cat_q     <= first_w[6:4];
              idx_q     <= first_w[3:0];
            end else begin
              state_q   <= S_DONE;
              mb_done_q <= 1'b1;
            end
          end
        end
        S_LEAD: begin
          state_q <= S_RUN;
          cyc_q   <= '0;
        end
        S_RUN: begin
          // scan_done is registered, so it is raised on entry to the last cycle.
          scan_done_q <= (cyc_q == CW'(BLK_CYCLES - 2)) && !next_w[7];
          if (cyc_q == CW'(BLK_CYCLES - 1)) begin
            cyc_q <= '0;
            if (next_w[7]) begin
              cat_q <= next_w[6:4];
              idx_q <= next_w[3:0];
            end else begin
              state_q     <= S_DONE;
              scan_en_q   <= 1'b0;
              scan_done_q <= 1'b0;
              mb_done_q   <= 1'b1;
              cat_q       <= '0;
              idx_q       <= '0;
            end
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        S_DONE: begin
          state_q   <= S_IDLE;
          mb_done_q <= 1'b0;
          busy_q    <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.scan_en   = scan_en_q;
  assign bus.scan_done = scan_done_q;
  assign bus.blk_cat   = cat_q;
  assign bus.blk_idx   = idx_q;
  assign bus.busy      = busy_q;
  assign bus.mb_done   = mb_done_q;

endmodule

// File: tb/tb_cavlc_blk_sched.sv
// Directed testbench for cavlc_blk_sched. Each macroblock is checked cycle by
// cycle against a hand-written block list; sample s=1 is the cycle right after
// the edge that accepts start.
module tb_cavlc_blk_sched;

  logic clk;
  logic rst_n;
  int   checks;
  int   fails;
  logic [6:0] exp_q[$];

  cavlc_blk_sched_if bus ();

  cavlc_blk_sched #(.BLK_CYCLES(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] cat, input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back({cat, 4'(i)});
  endtask

  task automatic check_idle(input string tag);
    check({tag, " scan_en"},   32'(bus.scan_en),   0);
    check({tag, " scan_done"}, 32'(bus.scan_done), 0);
    check({tag, " mb_done"},   32'(bus.mb_done),   0);
    check({tag, " busy"},      32'(bus.busy),      0);
    check({tag, " blk_cat"},   32'(bus.blk_cat),   0);
    check({tag, " blk_idx"},   32'(bus.blk_idx),   0);
  endtask

  // Issues start with the given MB parameters and checks n coded blocks from
  // exp_q. ign_s pulses a perturbing start at that sample; a second one is
  // pulsed in the mb_done cycle. abort_s asserts reset after that sample.
  task automatic run_mb(input string name, input logic [2:0] t, input logic [3:0] cl,
                        input logic [1:0] cc, input int n, input int ign_s, input int abort_s);
    int mdone_s;
    int last_s;
    logic [6:0] eb;
    mdone_s = (n > 0) ? 2 + 8 * n : 1;
    last_s  = mdone_s + 1;
    @(negedge clk);
    bus.mb_type    = t;
    bus.cbp_luma   = cl;
    bus.cbp_chroma = cc;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int s = 1; s <= last_s; s++) begin
      if (n > 0 && s == 1) eb = exp_q[0];
      else if (n > 0 && s >= 2 && s <= 1 + 8 * n) eb = exp_q[(s - 2) / 8];
      else eb = '0;
      check($sformatf("%s s=%0d scan_en", name, s), 32'(bus.scan_en),
            32'(n > 0 && s <= 1 + 8 * n));
      check($sformatf("%s s=%0d scan_done", name, s), 32'(bus.scan_done),
            32'(n > 0 && s == 1 + 8 * n));
      check($sformatf("%s s=%0d mb_done", name, s), 32'(bus.mb_done), 32'(s == mdone_s));
      check($sformatf("%s s=%0d busy", name, s), 32'(bus.busy), 32'(s <= mdone_s));
      check($sformatf("%s s=%0d blk_cat", name, s), 32'(bus.blk_cat), 32'(eb[6:4]));
      check($sformatf("%s s=%0d blk_idx", name, s), 32'(bus.blk_idx), 32'(eb[3:0]));
      if (s == abort_s) begin
        rst_n = 1'b0;
        @(negedge clk);
        check_idle($sformatf("%s after-reset", name));
        rst_n = 1'b1;
        exp_q.delete();
        return;
      end
      if (s == ign_s || s == mdone_s) begin
        bus.start      = 1'b1;
        bus.mb_type    = 3'd6;
        bus.cbp_luma   = 4'h0;
        bus.cbp_chroma = 2'd0;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    checks         = 0;
    fails          = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.mb_type    = 3'd0;
    bus.cbp_luma   = 4'h0;
    bus.cbp_chroma = 2'd0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    // start with mb_type IDLE is ignored
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_idle("idle_type s=1");
    @(negedge clk);
    check_idle("idle_type s=2");

    // I4x4, all luma coded, chroma DC+AC: 26 blocks; ignored starts at s=5 and mb_done
    push(3'd2, 0, 15); push(3'd3, 0, 1); push(3'd4, 0, 7);
    run_mb("i4x4_full", 3'd1, 4'hF, 2'd2, 26, 5, -1);

    // P16x16 with nothing coded
    run_mb("p16_empty", 3'd3, 4'h0, 2'd0, 0, -1, -1);

    // I16x16, only the luma DC block
    push(3'd0, 0, 0);
    run_mb("i16_dc", 3'd2, 4'h0, 2'd0, 1, -1, -1);

    // P8x8, groups 0 and 2, chroma DC only
    push(3'd2, 0, 3); push(3'd2, 8, 11); push(3'd3, 0, 1);
    run_mb("p8x8_0101", 3'd6, 4'b0101, 2'd1, 10, -1, -1);

    // I16x16 with only the last luma group: DC then AC 12..15
    push(3'd0, 0, 0); push(3'd1, 12, 15);
    run_mb("i16_g3", 3'd2, 4'b1000, 2'd0, 5, -1, -1);

    // reset at cyc 4 of block 3
    push(3'd2, 0, 15);
    run_mb("abort", 3'd1, 4'hF, 2'd0, 16, -1, 2 + 8 * 3 + 4);

    // fresh MB after reset; cbp_chroma=3 behaves as DC+AC
    push(3'd2, 4, 7); push(3'd3, 0, 1); push(3'd4, 0, 7);
    run_mb("p16x8_cc3", 3'd4, 4'b0010, 2'd3, 14, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
